// File: rtl/clk_gate_enable_ctrl.sv
// Enable-side controller for an integrated clock-gate: idle hysteresis, wake-up
// sequencing and per-port grants, all running on the free clock.
module clk_gate_enable_ctrl #(
   parameter  int NREQ        = 4,
   parameter  int IDLE_CYCLES = 8,
   parameter  int WAKE_CYCLES = 2,
   localparam int CW = $clog2(((IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES) + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [NREQ-1:0] req_i,
   input  logic            busy_i,
   input  logic            force_on_i,
   input  logic            se_i,
   output logic            e_o,
   output logic            te_o,
   output logic [NREQ-1:0] ack_o,
   output logic            gated_o,
   output logic [CW-1:0]   cnt_o
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_GATED = 2'd1,
      ST_WAKE  = 2'd2
   } state_e;

   localparam logic [CW-1:0] IDLE_RLD = CW'(IDLE_CYCLES - 1);
   localparam logic [CW-1:0] WAKE_RLD = CW'(WAKE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

   state_e          state_q, state_d;
   logic            e_q, e_d;
   logic            gated_q, gated_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            act_s;

   assign act_s = (|req_i) | busy_i | force_on_i;

   // Next-state and next-output decode for the RUN/GATED/WAKE sequencer.
   always_comb begin
      state_d = state_q;
      e_d     = e_q;
      gated_d = gated_q;
      ack_d   = ack_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RUN: begin
            e_d     = 1'b1;
            gated_d = 1'b0;
            if (act_s) begin
               cnt_d = IDLE_RLD;
               ack_d = req_i;
            end else if (cnt_q != CNT_ZERO) begin
               cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
               ack_d = req_i;
            end else begin
               state_d = ST_GATED;
               e_d     = 1'b0;
               gated_d = 1'b1;
               ack_d   = {NREQ{1'b0}};
            end
         end
         ST_GATED: begin
            ack_d = {NREQ{1'b0}};
            if (act_s) begin
               state_d = ST_WAKE;
               e_d     = 1'b1;
               gated_d = 1'b0;
               cnt_d   = WAKE_RLD;
            end else begin
               e_d     = 1'b0;
               gated_d = 1'b1;
               cnt_d   = CNT_ZERO;
            end
         end
         ST_WAKE: begin
            // Wake always runs to completion; grants resume only once back in RUN.
            e_d     = 1'b1;
            gated_d = 1'b0;
            ack_d   = {NREQ{1'b0}};
            if (cnt_q != CNT_ZERO) begin
               cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
            end else begin
               state_d = ST_RUN;
               cnt_d   = IDLE_RLD;
            end
         end
         default: begin
            state_d = ST_RUN;
            e_d     = 1'b1;
            gated_d = 1'b0;
            ack_d   = {NREQ{1'b0}};
            cnt_d   = IDLE_RLD;
         end
      endcase
   end

   // State and output registers; reset leaves the clock ungated.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_RUN;
         e_q     <= 1'b1;
         gated_q <= 1'b0;
         ack_q   <= {NREQ{1'b0}};
         cnt_q   <= IDLE_RLD;
      end else begin
         state_q <= state_d;
         e_q     <= e_d;
         gated_q <= gated_d;
         ack_q   <= ack_d;
         cnt_q   <= cnt_d;
      end
   end

   assign e_o     = e_q;
   assign gated_o = gated_q;
   assign ack_o   = ack_q;
   assign cnt_o   = cnt_q;
   assign te_o    = se_i | force_on_i;

endmodule
